// File: rtl/fi_mem_pkg.sv
// Shared types and helpers for the fault-injection memory responder:
// response entry layout, word/strobe widths and the byte-lane merge.
package fi_mem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  typedef struct packed {
    logic              error;
    logic [WORD_W-1:0] rdata;
  } rsp_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fi_mem_rsp_fifo.sv
// In-order response queue; pointers carry one extra wrap bit so that full
// and empty are told apart without a separate occupancy counter.
module fi_mem_rsp_fifo
  import fi_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  rsp_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output rsp_t head
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] rd_idx_s;
  rsp_t          mem_r [DEPTH];

  if (DEPTH > 1) begin : g_idx
    assign wr_idx_s = wr_ptr_r[IW-1:0];
    assign rd_idx_s = rd_ptr_r[IW-1:0];
  end else begin : g_single
    assign wr_idx_s = 1'b0;
    assign rd_idx_s = 1'b0;
  end

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = ((wr_ptr_r ^ rd_ptr_r) == PW'(DEPTH));
  assign head  = mem_r[rd_idx_s];

  // Pointer advance, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (!reset && push && !full) begin
      mem_r[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/fi_mem_responder.sv
// Single-port memory responder with programmable grant/response latency.
// Define FI_MEM_RESPONDER_ERR_EN to flag accesses above 2^AW words as errors.
module fi_mem_responder
  import fi_mem_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DEPTH   = 2,
  parameter int GNT_LAT = 0,
  parameter int RSP_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_wen,
  input  logic [STRB_W-1:0] mem_strb,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic [31:0]       mem_addr,
  output logic              mem_gnt,
  output logic              mem_recv,
  input  logic              mem_ack,
  output logic              mem_error,
  output logic [WORD_W-1:0] mem_rdata
);

  localparam int GW = (GNT_LAT > 0) ? $clog2(GNT_LAT + 1) : 1;
  localparam int RW = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;

  logic [GW-1:0]     gcnt_r;
  logic [RW-1:0]     rcnt_r;
  logic [WORD_W-1:0] store_r [2**AW];
  logic [AW-1:0]     widx_s;
  logic              oor_s;
  logic              accept_s;
  logic              complete_s;
  logic              full_s;
  logic              empty_s;
  rsp_t              rsp_s;
  rsp_t              head_s;
  logic              unused_s;

  assign widx_s = mem_addr[AW+1:2];

`ifdef FI_MEM_RESPONDER_ERR_EN
  assign oor_s    = |mem_addr[31:AW+2];
  assign unused_s = ^mem_addr[1:0];
`else
  assign oor_s    = 1'b0;
  assign unused_s = ^{mem_addr[1:0], mem_addr[31:AW+2], head_s.error};
`endif

  // Reset forces every output low in the same cycle, so no acceptance or
  // store write can happen while it is held.
  assign mem_gnt    = !reset && mem_req && !full_s && (gcnt_r == GW'(GNT_LAT));
  assign accept_s   = mem_req && mem_gnt;
  assign mem_recv   = !reset && !empty_s && (rcnt_r == RW'(RSP_LAT - 1));
  assign complete_s = mem_recv && mem_ack;

  // Response entry captured at acceptance: reads sample the store now.
  always_comb begin
    rsp_s = '0;
    if (oor_s) begin
      rsp_s.error = 1'b1;
    end else if (!mem_wen) begin
      rsp_s.rdata = store_r[widx_s];
    end else begin
      rsp_s.rdata = '0;
    end
  end

  // Response fields follow the FIFO head and read as zero when idle.
  always_comb begin
    mem_rdata = '0;
    mem_error = 1'b0;
    if (!reset && !empty_s) begin
      mem_rdata = head_s.rdata;
`ifdef FI_MEM_RESPONDER_ERR_EN
      mem_error = head_s.error;
`endif
    end else begin
      mem_rdata = '0;
    end
  end

  // Grant latency counter, saturating at GNT_LAT.
  always_ff @(posedge clock) begin
    if (reset || !mem_req || accept_s) begin
      gcnt_r <= '0;
    end else if (gcnt_r != GW'(GNT_LAT)) begin
      gcnt_r <= gcnt_r + GW'(1);
    end
  end

  // Response latency counter for the oldest outstanding entry.
  always_ff @(posedge clock) begin
    if (reset || empty_s || complete_s) begin
      rcnt_r <= '0;
    end else if (!mem_recv) begin
      rcnt_r <= rcnt_r + RW'(1);
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clock) begin
    if (accept_s && mem_wen && !oor_s) begin
      store_r[widx_s] <= merge_bytes(store_r[widx_s], mem_wdata, mem_strb);
    end
  end

  fi_mem_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_rsp_fifo (
    .clock(clock),
    .reset(reset),
    .push (accept_s),
    .din  (rsp_s),
    .pop  (complete_s),
    .full (full_s),
    .empty(empty_s),
    .head (head_s)
  );

endmodule

// File: tb/tb_fi_mem_responder.sv
// Directed bench for fi_mem_responder: a default-latency instance checked
// against a scoreboard, plus a GNT_LAT=2/RSP_LAT=3 instance for latency.
module tb_fi_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, wen, ack, req1, ack1;
  logic [3:0]  strb;
  logic [31:0] wdata, addr;
  logic        gnt, recv, err;
  logic [31:0] rdata;
  logic        gnt1, recv1, err1;
  logic [31:0] rdata1;

  int          total  = 0;
  int          passed = 0;
  logic [32:0] sb [$];
  logic [31:0] model [int];

  always #5 clock = ~clock;

  fi_mem_responder u_dut (
    .clock(clock), .reset(reset), .mem_req(req), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .mem_addr(addr), .mem_gnt(gnt),
    .mem_recv(recv), .mem_ack(ack), .mem_error(err), .mem_rdata(rdata)
  );

  fi_mem_responder #(.GNT_LAT(2), .RSP_LAT(3)) u_lat (
    .clock(clock), .reset(reset), .mem_req(req1), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .mem_addr(addr), .mem_gnt(gnt1),
    .mem_recv(recv1), .mem_ack(ack1), .mem_error(err1), .mem_rdata(rdata1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc();
    req = 1'b1; wen = 1'b1; addr = a; wdata = d; strb = s;
    mid();
    check1("wr_gnt", gnt, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc();
    req = 1'b1; wen = 1'b0; addr = a;
    mid();
    check1("rd_gnt", gnt, 1'b1);
  endtask

  task automatic idle();
    cyc();
    req = 1'b0;
    mid();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cyc();
      mid();
      n++;
    end
    check("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  task automatic lat_txn(input logic w, input logic [31:0] d, input logic [31:0] exp);
    cyc();
    req1 = 1'b1; wen = w; addr = 32'h10; wdata = d; strb = 4'hF;
    mid(); check1("lat_gnt_c1", gnt1, 1'b0);
    cyc(); mid(); check1("lat_gnt_c2", gnt1, 1'b0);
    cyc(); mid(); check1("lat_gnt_c3", gnt1, 1'b1);
    cyc(); req1 = 1'b0;
    mid(); check1("lat_recv_p1", recv1, 1'b0);
    cyc(); mid(); check1("lat_recv_p2", recv1, 1'b0);
    cyc(); mid(); check1("lat_recv_p3", recv1, 1'b1);
    check("lat_rdata", rdata1, exp);
    cyc(); mid(); check1("lat_popped", recv1, 1'b0);
  endtask

  // Scoreboard: push expected entry on acceptance, pop on completion.
  always @(negedge clock) begin : mon
    logic [31:0] m_word;
    logic [32:0] m_exp;
    logic        m_oor;
    int          m_idx;
    if (reset) begin
      sb.delete();
    end else begin
      if (recv && ack) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          m_exp = sb.pop_front();
          check("sb_rdata", rdata, m_exp[31:0]);
          check1("sb_error", err, m_exp[32]);
        end
      end
      if (req && gnt) begin
        m_oor = 1'b0;
`ifdef FI_MEM_RESPONDER_ERR_EN
        m_oor = (addr[31:12] != 20'd0);
`endif
        m_idx  = int'(addr[11:2]);
        m_word = model.exists(m_idx) ? model[m_idx] : 32'd0;
        if (m_oor) begin
          sb.push_back({1'b1, 32'd0});
        end else if (wen) begin
          for (int i = 0; i < 4; i++) begin
            if (strb[i]) m_word[8*i +: 8] = wdata[8*i +: 8];
          end
          model[m_idx] = m_word;
          sb.push_back({1'b0, 32'd0});
        end else begin
          sb.push_back({1'b0, m_word});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; wen = 1'b0; strb = 4'h0; wdata = 32'h0;
    addr = 32'h0; ack = 1'b1; req1 = 1'b0; ack1 = 1'b1;
    cyc();
    req = 1'b1; wen = 1'b1; addr = 32'h30; strb = 4'hF; wdata = 32'hDEADBEEF;
    mid();
    check1("rst_gnt", gnt, 1'b0);
    check1("rst_recv", recv, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check1("rst_err", err, 1'b0);
    cyc(); reset = 1'b0; req = 1'b0;
    mid();
    check1("idle_recv", recv, 1'b0);

    // Full-word write then read-back with single-cycle response.
    wr(32'h10, 32'h11223344, 4'hF);
    rd(32'h10);
    idle();
    check1("rd_recv", recv, 1'b1);
    check("rd_data", rdata, 32'h11223344);

    // Partial-strobe write over zero.
    wr(32'h20, 32'h0, 4'hF);
    wr(32'h20, 32'hAABBCCDD, 4'b0101);
    rd(32'h20);
    idle();
    check1("strb_recv", recv, 1'b1);
    check("strb_data", rdata, 32'h00BB00DD);
    wr(32'h30, 32'h01010101, 4'hF);
    wr(32'h0, 32'hCAFEF00D, 4'hF);
    idle();
    drain();

    // Full FIFO with ack held low: third request stalls, data stable.
    ack = 1'b0;
    rd(32'h10);
    rd(32'h20);
    cyc(); addr = 32'h30;
    mid();
    check1("full_gnt", gnt, 1'b0);
    check1("full_recv", recv, 1'b1);
    check("stall_data", rdata, 32'h11223344);
    cyc(); mid();
    check1("full_gnt2", gnt, 1'b0);
    check("stall_data2", rdata, 32'h11223344);
    cyc(); ack = 1'b1;
    mid();
    check1("full_pop_gnt", gnt, 1'b0);
    cyc(); ack = 1'b0;
    mid();
    check1("after_pop_gnt", gnt, 1'b1);
    check("after_pop_data", rdata, 32'h00BB00DD);
    cyc(); req = 1'b0; ack = 1'b1;
    mid();
    drain();

    // Reset with two responses pending; write during reset must be dropped.
    ack = 1'b0;
    rd(32'h10);
    rd(32'h20);
    cyc();
    reset = 1'b1; req = 1'b1; wen = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; strb = 4'hF;
    mid();
    check1("rst2_gnt", gnt, 1'b0);
    check1("rst2_recv", recv, 1'b0);
    check("rst2_rdata", rdata, 32'h0);
    cyc(); reset = 1'b0; req = 1'b0; ack = 1'b1;
    mid();
    check1("post_rst_recv", recv, 1'b0);
    check("post_rst_rdata", rdata, 32'h0);
    rd(32'h30);
    idle();
    check1("keep_recv", recv, 1'b1);
    check("keep_data", rdata, 32'h01010101);

    // Address above the store range.
    rd(32'h00001000);
    idle();
    check1("oor_recv", recv, 1'b1);
`ifdef FI_MEM_RESPONDER_ERR_EN
    check1("oor_err", err, 1'b1);
    check("oor_rdata", rdata, 32'h0);
`else
    check1("oor_err", err, 1'b0);
    check("oor_rdata", rdata, 32'hCAFEF00D);
`endif
    drain();

    // Grant and response latency instance.
    lat_txn(1'b1, 32'h55AA55AA, 32'h0);
    lat_txn(1'b0, 32'h0, 32'h55AA55AA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
